// File: rtl/ps2_keyboard_rx.sv
// Purpose: PS/2 keyboard receiver. It deframes 11-bit device-to-host frames into bytes for the KBDR/KBSR path.
// Latency: Data/Ready/flags update on the Clk edge that ends the cycle holding the stop-bit sample event.
// Backpressure: Ready is held until Ack. A good frame arriving while Ready=1 is dropped and sets Overrun.
//
// Ports:
//   Clk       system clock; all state updates on the rising edge
//   Reset     asynchronous, active-low reset
//   PS2_Clk   raw PS/2 clock pin (asynchronous, idles high)
//   PS2_Data  raw PS/2 data pin (asynchronous, idles high)
//   Ack       one-cycle pulse: byte consumed; clears Ready, Overrun and ParityErr
//   Data      last good received byte
//   Ready     level: unread byte valid in Data
//   Overrun   sticky: good frame arrived while Ready=1
//   ParityErr sticky: frame discarded because of bad parity
module ps2_keyboard_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  input  logic       Ack,
  output logic [7:0] Data,
  output logic       Ready,
  output logic       Overrun,
  output logic       ParityErr
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_q, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          sample_evt, tmo_abort, take;
  logic          frame_good, frame_perr;

  // Two-flop synchronizers; reset to the idle-high level of the bus.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_Clk;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_Data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: the filtered clock follows the synchronized clock only
  // after FILTER_LEN consecutive samples that disagree with the current level.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      filt_q    <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_q;
      if (clk_s2 == filt_q) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_q   <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign sample_evt = filt_prev & ~filt_q;

  // An abandoned frame takes precedence over a sample landing in the same cycle.
  assign tmo_abort = (state_q != IDLE) && (tmo_cnt == TW'(TIMEOUT - 1));
  assign take      = sample_evt && !tmo_abort;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tmo_cnt <= '0;
    end else if (sample_evt || state_q == IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_good = 1'b0;
    frame_perr = 1'b0;
    if (tmo_abort) begin
      state_d = IDLE;
    end else if (sample_evt) begin
      case (state_q)
        IDLE:    if (!dat_s2) state_d = DATA;
        DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP: begin
          state_d = IDLE;
          // Odd parity: data bits plus parity bit must contain an odd count of ones.
          if (dat_s2 && (^{shift_q, par_q})) frame_good = 1'b1;
          else if (dat_s2) frame_perr = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame datapath: the bit counter is held at zero in IDLE, so every
  // frame starts writing at D0.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      bit_cnt <= '0;
    end else if (take) begin
      if (state_q == DATA) begin
        shift_q[bit_cnt] <= dat_s2;
        bit_cnt          <= bit_cnt + 1'b1;
      end
      if (state_q == PARITY) begin
        par_q <= dat_s2;
      end
    end
  end

  // The Ack clear is applied first, so a frame completing in the same cycle
  // can set Ready or ParityErr over it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Data      <= '0;
      Ready     <= 1'b0;
      Overrun   <= 1'b0;
      ParityErr <= 1'b0;
    end else begin
      if (Ack) begin
        Ready     <= 1'b0;
        Overrun   <= 1'b0;
        ParityErr <= 1'b0;
      end
      if (frame_good) begin
        if (!Ready || Ack) begin
          Data  <= shift_q;
          Ready <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end
      if (frame_perr) begin
        ParityErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
module tb_ps2_keyboard_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       r;
    logic       o;
    logic       p;
  } obs_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       PS2_Clk = 1'b1;
  logic       PS2_Data = 1'b1;
  logic       Ack = 1'b0;
  logic [7:0] Data;
  logic       Ready, Overrun, ParityErr;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  obs_t prev_obs;
  logic mon_en = 1'b0;

  ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT(1000)) dut (
    .Clk(Clk), .Reset(Reset), .PS2_Clk(PS2_Clk), .PS2_Data(PS2_Data), .Ack(Ack),
    .Data(Data), .Ready(Ready), .Overrun(Overrun), .ParityErr(ParityErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic obs_t mk_obs(input logic [7:0] d, input logic r, input logic o, input logic p);
    obs_t x;
    x.d = d; x.r = r; x.o = o; x.p = p;
    return x;
  endfunction

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stp);
    return {stp, par, d, 1'b0};
  endfunction

  // Monitor: every change of the output tuple must match the next queued expectation.
  always @(negedge Clk) begin
    if (mon_en) begin
      obs_t cur;
      cur = {Data, Ready, Overrun, ParityErr};
      if (cur !== prev_obs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output_change", 32'(cur), 32'(prev_obs));
        end else begin
          obs_t e;
          e = exp_q.pop_front();
          chk("scoreboard_tuple", 32'(cur), 32'(e));
        end
        prev_obs = cur;
      end
    end
  end

  // Drives the first n bits of a frame LSB first: data changes mid-high, 40-cycle half periods.
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_Data = fr[i];
      repeat (20) @(posedge Clk);
      PS2_Clk = 1'b0;
      repeat (40) @(posedge Clk);
      PS2_Clk = 1'b1;
      repeat (20) @(posedge Clk);
    end
    PS2_Data = 1'b1;
  endtask

  task automatic ack_pulse(input string name);
    @(posedge Clk); #1 Ack = 1'b1;
    @(posedge Clk); #1 Ack = 1'b0;
    chk(name, 32'(Ready), 32'(0));
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    chk("reset_data", 32'(Data), 32'h00);
    chk("reset_flags", 32'({Ready, Overrun, ParityErr}), 32'(0));
    prev_obs = mk_obs(8'h00, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    repeat (10) @(posedge Clk);

    // 1: good frame, then Ack
    exp_q.push_back(mk_obs(8'h1C, 1, 0, 0));
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
    repeat (20) @(posedge Clk);
    exp_q.push_back(mk_obs(8'h1C, 0, 0, 0));
    ack_pulse("ack1_ready_clear");

    // 2: bad parity
    exp_q.push_back(mk_obs(8'h1C, 0, 0, 1));
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
    repeat (20) @(posedge Clk);
    exp_q.push_back(mk_obs(8'h1C, 0, 0, 0));
    ack_pulse("ack2_ready_low");

    // 3: overrun
    exp_q.push_back(mk_obs(8'h1C, 1, 0, 0));
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
    exp_q.push_back(mk_obs(8'h1C, 1, 1, 0));
    send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 11);
    repeat (20) @(posedge Clk);
    exp_q.push_back(mk_obs(8'h1C, 0, 0, 0));
    ack_pulse("ack3_ready_clear");

    // 4: short clock glitch must be ignored, then a good frame
    repeat (20) @(posedge Clk);
    PS2_Clk = 1'b0;
    repeat (3) @(posedge Clk);
    PS2_Clk = 1'b1;
    repeat (50) @(posedge Clk);
    exp_q.push_back(mk_obs(8'h5A, 1, 0, 0));
    send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 11);
    repeat (20) @(posedge Clk);
    exp_q.push_back(mk_obs(8'h5A, 0, 0, 0));
    ack_pulse("ack4_ready_clear");

    // 5: partial frame abandoned by timeout, then a full frame
    send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 5);
    repeat (1010) @(posedge Clk);
    exp_q.push_back(mk_obs(8'h5A, 1, 0, 0));
    send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 11);
    repeat (20) @(posedge Clk);

    // 6: reset mid-frame, then a normal frame
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 5);
    exp_q.push_back(mk_obs(8'h00, 0, 0, 0));
    #3 Reset = 1'b0;
    #1 chk("async_reset_outputs", 32'({Data, Ready, Overrun, ParityErr}), 32'(0));
    repeat (5) @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (20) @(posedge Clk);
    exp_q.push_back(mk_obs(8'h29, 1, 0, 0));
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 11);

    // Drain: every expected output change must have been observed.
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge Clk);
    end
    repeat (5) @(posedge Clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
